// File: rtl/keypad_scan_ctrl_if.sv
// Keypad scan controller signal bundle: raw keypad pins on one side,
// validated key codes toward the consuming logic on the other.
interface keypad_scan_ctrl_if;
    logic [3:0] rows;       // raw keypad rows, active-low, asynchronous
    logic       scan_en;    // high = column advance allowed while scanning
    logic [3:0] cols;       // active-low one-hot column drive
    logic [3:0] key_code;   // hex value of the last accepted key
    logic       key_valid;  // one-cycle pulse per accepted press
    logic       key_held;   // high while the accepted key stays pressed

    modport slave (
        input  rows,
        input  scan_en,
        output cols,
        output key_code,
        output key_valid,
        output key_held
    );

    modport master (
        output rows,
        output scan_en,
        input  cols,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scan controller. Drives one column at a time, samples
// the synchronized rows, freezes on a pressed column, debounces press and
// release, and emits one key code pulse per physical press.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 1200,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              reset,
    keypad_scan_ctrl_if.slave kp
);

    typedef enum logic [1:0] {
        S_SCAN        = 2'd0,
        S_DEB_PRESS   = 2'd1,
        S_HELD        = 2'd2,
        S_DEB_RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LAST   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    state_t           r_state,     w_state_nxt;
    logic [1:0]       r_col_idx,   w_col_idx_nxt;
    logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic [1:0]       r_lat_row,   w_lat_row_nxt;
    logic [3:0]       r_key_code,  w_key_code_nxt;
    logic             r_key_valid, w_key_valid_nxt;
    logic             r_key_held,  w_key_held_nxt;
    logic [3:0]       r_rows_meta;
    logic [3:0]       r_rows_s;
    logic             w_lat_bit;

    // Lowest-index row that is pulled low; only meaningful when one is low.
    function automatic logic [1:0] f_lowest_low(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Physical keypad legend, indexed by row then column.
    function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    assign w_lat_bit = r_rows_s[r_lat_row];

    // Two-flop synchronizer for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rows_meta <= 4'b1111;
            r_rows_s    <= 4'b1111;
        end else begin
            r_rows_meta <= kp.rows;
            r_rows_s    <= r_rows_meta;
        end
    end

    // State, column, shared counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_SCAN;
            r_col_idx   <= 2'd0;
            r_cnt       <= '0;
            r_lat_row   <= 2'd0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lat_row   <= w_lat_row_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_key_held  <= w_key_held_nxt;
        end
    end

    // Next-state logic: scan, debounce press, hold, debounce release.
    // The counter is cleared on every state change; mid-window glitches are
    // ignored because only the sample at the end of a window decides.
    always_comb begin
        w_state_nxt     = r_state;
        w_col_idx_nxt   = r_col_idx;
        w_cnt_nxt       = r_cnt;
        w_lat_row_nxt   = r_lat_row;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = 1'b0;
        w_key_held_nxt  = r_key_held;

        case (r_state)
            S_SCAN: begin
                if (kp.scan_en) begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_rows_s != 4'b1111) begin
                            w_lat_row_nxt = f_lowest_low(r_rows_s);
                            w_state_nxt   = S_DEB_PRESS;
                        end else begin
                            w_col_idx_nxt = r_col_idx + 2'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
            end

            S_DEB_PRESS: begin
                if (r_cnt == DEBOUNCE_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_lat_bit) begin
                        w_state_nxt     = S_HELD;
                        w_key_code_nxt  = f_key_map(r_lat_row, r_col_idx);
                        w_key_valid_nxt = 1'b1;
                        w_key_held_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_SCAN;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_HELD: begin
                if (w_lat_bit) begin
                    w_state_nxt = S_DEB_RELEASE;
                    w_cnt_nxt   = '0;
                end
            end

            S_DEB_RELEASE: begin
                if (r_cnt == DEBOUNCE_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_lat_bit) begin
                        w_state_nxt    = S_SCAN;
                        w_key_held_nxt = 1'b0;
                        w_col_idx_nxt  = r_col_idx + 2'd1;
                    end else begin
                        w_state_nxt = S_HELD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            default: begin
                w_state_nxt = S_SCAN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign kp.cols      = ~(4'b0001 << r_col_idx);
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad. It drives the columns one at a time and samples the rows. On a press it freezes the scan on that column, debounces the press and the release, and emits one validated hex key code per physical press. It sits between the keypad pins and the display/logic that consumes key codes.

Parameters:
SETTLE_CYCLES, 4, clk cycles a column is driven before rows are sampled (min 3, covers the synchronizer)
DEBOUNCE_CYCLES, 1200, clk cycles a press or release must stay stable before it is accepted
CNT_W, 20, width of the shared settle/debounce counter; must hold max(SETTLE_CYCLES, DEBOUNCE_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
rows  in  4  raw keypad rows, active-low (pulled up), asynchronous to clk
scan_en  in  1  high = scanning allowed; low pauses column advance in SCAN only
cols  out  4  column drive, active-low one-hot
key_code  out  4  hex value of last accepted key
key_valid  out  1  one-cycle pulse when a press is accepted
key_held  out  1  high while an accepted key remains pressed

Behaviour:
- Reset (async assert, sync release), all to these values:
  - state=SCAN, col_idx=0, cols=4'b1110
  - counter=0, key_code=0, key_valid=0, key_held=0
  - synchronizer flops=4'b1111
- rows pass through a 2-flop synchronizer (rows_s); all decisions use rows_s only.
- Key map [row][col]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- cols = ~(4'b0001 << col_idx) at all times.
- State machine; counter resets to 0 on every state change:
  - SCAN:
    - Counter increments while scan_en=1; holds while scan_en=0.
    - When counter reaches SETTLE_CYCLES-1, sample rows_s.
    - If any bit is 0: latch lat_row = lowest-index low row, keep col_idx, go DEB_PRESS.
    - Else: col_idx = (col_idx+1) mod 4 (3 wraps to 0), counter=0, stay in SCAN.
  - DEB_PRESS:
    - col_idx frozen; counter increments each cycle.
    - At counter == DEBOUNCE_CYCLES-1, if rows_s[lat_row]==0: go HELD, key_code <= map[lat_row][col_idx], key_valid=1 for exactly that one cycle, key_held<=1.
    - Else: bounce rejected, advance col_idx, go SCAN, no outputs change.
  - HELD:
    - col_idx frozen.
    - When rows_s[lat_row]==1, go DEB_RELEASE.
    - Other rows in the same column going low are ignored; keys in other columns are invisible because that column is not driven.
  - DEB_RELEASE:
    - Counter increments.
    - At DEBOUNCE_CYCLES-1, if rows_s[lat_row]==1: key_held<=0, advance col_idx, go SCAN.
    - If rows_s[lat_row]==0 at that point: return to HELD, no new key_valid.
    - A mid-window transition does not restart the count; only the final sample decides.
- Latency:
  - Row change to rows_s: 2 cycles.
  - Press to key_valid: at most 4*SETTLE_CYCLES + DEBOUNCE_CYCLES + 3 cycles.
- key_code holds its value until the next accepted press; it is not cleared on release.
- Multiple keys in the same column at once: lowest row index wins; it alone is tracked until release.
- Reset asserted mid-operation: all state and outputs return to reset values immediately; no key_valid is produced.
- scan_en=0 has no effect in DEB_PRESS, HELD or DEB_RELEASE, so an in-progress key always completes.
- Default state encoding falls back to SCAN.

Test Plan:
Common settings: SETTLE_CYCLES=4, DEBOUNCE_CYCLES=16.
1. Reset, rows=4'b1111 for 40 cycles -> cols cycles 1110,1101,1011,0111,1110 every 4 cycles; key_valid never asserts.
2. Hold rows[1]=0 only while cols=1011 (key 6), stable for 40 cycles -> cols freezes at 1011, single key_valid pulse, key_code=4'h6, key_held=1. Release and wait 20 cycles -> key_held=0, scan resumes at cols=0111.
3. Pulse rows[0]=0 for 5 cycles at cols=1110 -> no key_valid, key_code stays 0, scan resumes at cols=1101.
4. Press key D (r3, c3) for 40 cycles, bounce high for 3 cycles during HELD, keep pressed, then release cleanly -> exactly one key_valid, key_code=4'hD, key_held stays 1 through the bounce.
5. rows[2] and rows[0] low together at cols=1101 -> key_code=4'h2, one pulse. Press r3 in col 0 during HELD -> ignored.
6. Assert reset during DEB_PRESS -> cols=1110, key_valid=0, key_held=0 immediately. scan_en=0 in SCAN for 20 cycles -> cols constant.
